// File: rtl/trng_sample_ctrl_if.sv
// Handshake/data bundle between the TRNG sample controller and its environment.
//   enable      : level request to run the generator
//   raw_bit     : oscillator sample bit, synchronous to clk
//   clr_fail    : one-cycle pulse clearing a latched health failure
//   word_ready  : consumer accepts the word when high with word_valid
//   ro_en       : oscillator activate outputs (bit 0 -> RO 1, bit 1 -> RO 2)
//   word        : collected random byte
//   word_valid  : word holds an unconsumed byte
//   health_fail : repetition-count failure latched
//   busy        : controller is active (not IDLE, not FAIL)
interface trng_sample_ctrl_if;
   logic       enable;
   logic       raw_bit;
   logic       clr_fail;
   logic       word_ready;
   logic [1:0] ro_en;
   logic [7:0] word;
   logic       word_valid;
   logic       health_fail;
   logic       busy;

   // Environment side: drives requests and oscillator bits, observes results.
   modport master (
      output enable, raw_bit, clr_fail, word_ready,
      input  ro_en, word, word_valid, health_fail, busy
   );

   // Controller side.
   modport slave (
      input  enable, raw_bit, clr_fail, word_ready,
      output ro_en, word, word_valid, health_fail, busy
   );
endinterface

// File: rtl/trng_sample_ctrl.sv
// TRNG sample controller: warms up the ring oscillators, collects 8 raw bits
// per byte, runs a repetition-count health test and hands bytes out over a
// valid/ready handshake.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : trng_sample_ctrl_if.slave (see interface header for signals)
// Parameters:
//   WARMUP    : oscillator warm-up cycles before the first sample (1..255)
//   REP_LIMIT : run length of identical bits that trips the health test (2..31)
module trng_sample_ctrl #(
   parameter int unsigned WARMUP    = 16,
   parameter int unsigned REP_LIMIT = 8
) (
   input logic                clk,
   input logic                rst_n,
   trng_sample_ctrl_if.slave  bus
);

   localparam int unsigned WARM_W = 8;
   localparam int unsigned BIT_W  = 3;
   localparam int unsigned RUN_W  = $clog2(REP_LIMIT + 1);
   localparam int unsigned SHR_W  = 7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WARMUP,
      ST_COLLECT,
      ST_HOLD,
      ST_FAIL
   } state_e;

   state_e             state_q, state_d;
   logic [WARM_W-1:0]  warm_q, warm_d;
   logic [BIT_W-1:0]   bit_q, bit_d;
   logic [RUN_W-1:0]   run_q, run_d, run_next;
   logic               prev_q, prev_d;
   logic [SHR_W-1:0]   shift_q, shift_d;
   logic [7:0]         word_q, word_d;
   logic               valid_q, valid_d;
   logic [1:0]         ro_en_q, ro_en_d;
   logic               busy_q, busy_d;
   logic               fail_q, fail_d;
   logic               active_d;

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         warm_q  <= '0;
         bit_q   <= '0;
         run_q   <= '0;
         prev_q  <= 1'b0;
         shift_q <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
         ro_en_q <= 2'b00;
         busy_q  <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         warm_q  <= warm_d;
         bit_q   <= bit_d;
         run_q   <= run_d;
         prev_q  <= prev_d;
         shift_q <= shift_d;
         word_q  <= word_d;
         valid_q <= valid_d;
         ro_en_q <= ro_en_d;
         busy_q  <= busy_d;
         fail_q  <= fail_d;
      end
   end

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d  = state_q;
      warm_d   = warm_q;
      bit_d    = bit_q;
      run_d    = run_q;
      prev_d   = prev_q;
      shift_d  = shift_q;
      word_d   = word_q;
      valid_d  = valid_q;
      run_next = '0;

      // run_q == 0 marks the first sample after warm-up.
      if (run_q == '0 || bus.raw_bit != prev_q) begin
         run_next = RUN_W'(1);
      end else if (run_q == RUN_W'(REP_LIMIT)) begin
         run_next = run_q;
      end else begin
         run_next = run_q + RUN_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.enable) begin
               state_d = ST_WARMUP;
               warm_d  = '0;
               bit_d   = '0;
               run_d   = '0;
               shift_d = '0;
            end
         end
         ST_WARMUP: begin
            if (!bus.enable) begin
               state_d = ST_IDLE;
            end else if (warm_q == WARM_W'(WARMUP - 1)) begin
               state_d = ST_COLLECT;
            end else begin
               warm_d = warm_q + WARM_W'(1);
            end
         end
         ST_COLLECT: begin
            if (!bus.enable) begin
               state_d = ST_IDLE;
               bit_d   = '0;
               shift_d = '0;
            end else begin
               run_d   = run_next;
               prev_d  = bus.raw_bit;
               shift_d = {shift_q[SHR_W-2:0], bus.raw_bit};
               // Health failure beats a byte completing on the same edge.
               if (run_next == RUN_W'(REP_LIMIT)) begin
                  state_d = ST_FAIL;
                  bit_d   = '0;
                  shift_d = '0;
               end else if (bit_q == BIT_W'(7)) begin
                  state_d = ST_HOLD;
                  word_d  = {shift_q, bus.raw_bit};
                  valid_d = 1'b1;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
         ST_HOLD: begin
            if (valid_q && bus.word_ready) begin
               valid_d = 1'b0;
               state_d = bus.enable ? ST_COLLECT : ST_IDLE;
            end
         end
         ST_FAIL: begin
            valid_d = 1'b0;
            if (bus.clr_fail) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      active_d = (state_d == ST_WARMUP) || (state_d == ST_COLLECT) ||
                 (state_d == ST_HOLD);
      ro_en_d  = active_d ? 2'b11 : 2'b00;
      busy_d   = active_d;
      fail_d   = (state_d == ST_FAIL);
   end

   assign bus.ro_en       = ro_en_q;
   assign bus.word        = word_q;
   assign bus.word_valid  = valid_q;
   assign bus.health_fail = fail_q;
   assign bus.busy        = busy_q;

endmodule

// File: tb/tb_trng_sample_ctrl.sv
// Self-checking bench for trng_sample_ctrl: stimulus pushes expected words /
// failure events (with their due cycle) into a queue, a negedge monitor pops
// and compares whenever word_valid or health_fail rises.
module tb_trng_sample_ctrl;

   localparam int unsigned WARMUP    = 16;
   localparam int unsigned REP_LIMIT = 8;

   typedef struct packed {
      logic        is_fail;
      logic [7:0]  data;
      logic [31:0] cyc;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n;
   trng_sample_ctrl_if bus ();

   trng_sample_ctrl #(.WARMUP(WARMUP), .REP_LIMIT(REP_LIMIT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] cyc = 0;
   ev_t         exp_q[$];
   bit          vld_prev = 1'b0;
   bit          fail_prev = 1'b0;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (cyc > 50000) begin
         $display("FAIL watchdog: cycle %0d reached, required finish before 50000", cyc);
         $fatal(1);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_ev(input bit f, input logic [7:0] d, input logic [31:0] c);
      ev_t e;
      e.is_fail = f;
      e.data    = d;
      e.cyc     = c;
      exp_q.push_back(e);
   endtask

   task automatic mon_event(input bit f, input logic [7:0] d);
      ev_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event: got kind=%0d word=%02h at cycle %0d, required none", f, d, cyc);
      end else begin
         e = exp_q.pop_front();
         check("event_kind", 32'(f), 32'(e.is_fail));
         if (!f) check("word_value", 32'(d), 32'(e.data));
         check("event_cycle", cyc, e.cyc);
      end
   endtask

   // Monitor: compare on every rising word_valid / health_fail.
   always @(negedge clk) begin
      if (bus.word_valid && !vld_prev)    mon_event(1'b0, bus.word);
      if (bus.health_fail && !fail_prev)  mon_event(1'b1, 8'h00);
      vld_prev  = bus.word_valid;
      fail_prev = bus.health_fail;
   end

   function automatic bit gen_bit(input int mode, input int k);
      case (mode)
         1:       return (k % 2 == 0);        // 1,0,1,0,...
         2:       return ((k / 2) % 2 == 0);  // 1,1,0,0,...
         3:       return 1'b0;
         default: return 1'($urandom);
      endcase
   endfunction

   // Length of the run of identical bits at the end of the sample history.
   function automatic int trail_run(input bit h[$]);
      int n = 0;
      for (int i = h.size() - 1; i >= 0; i--) begin
         if (h[i] == h[h.size()-1]) n++;
         else break;
      end
      return n;
   endfunction

   task automatic fail_recovery();
      check("fail_flag", 32'(bus.health_fail), 32'd1);
      check("fail_ro_en", 32'(bus.ro_en), 32'd0);
      check("fail_busy", 32'(bus.busy), 32'd0);
      check("fail_no_valid", 32'(bus.word_valid), 32'd0);
      bus.enable = 1'b1;
      step();
      check("fail_sticky", 32'(bus.health_fail), 32'd1);
      bus.clr_fail = 1'b1;
      step();
      bus.clr_fail = 1'b0;
      check("clr_to_idle_flag", 32'(bus.health_fail), 32'd0);
      check("clr_to_idle_busy", 32'(bus.busy), 32'd0);
      step();
      check("idle_to_warmup_busy", 32'(bus.busy), 32'd1);
      check("idle_to_warmup_ro", 32'(bus.ro_en), 32'd3);
      bus.enable = 1'b0;
      step();
      check("warmup_abort_busy", 32'(bus.busy), 32'd0);
   endtask

   // One enable session: warm-up then nwords bytes; last handshake drops enable.
   task automatic episode(input int nwords, input int mode, input int dmin, input int dmax);
      bit          hist[$];
      int          k = 0;
      bit          failed = 1'b0;
      logic [31:0] due;
      logic [7:0]  byte_v = 8'h00;
      int          d;
      bit          b;
      bus.word_ready = 1'b0;
      bus.enable     = 1'b1;
      step();
      due = cyc + 32'(WARMUP) + 32'd8;
      check("warmup_entry_busy", 32'(bus.busy), 32'd1);
      check("warmup_entry_ro", 32'(bus.ro_en), 32'd3);
      repeat (WARMUP) begin
         bus.raw_bit  = 1'($urandom);
         bus.clr_fail = ($urandom_range(0, 3) == 0);
         step();
      end
      bus.clr_fail = 1'b0;
      for (int w = 0; w < nwords; w++) begin
         for (int i = 0; i < 8; i++) begin
            b = gen_bit(mode, k);
            k++;
            bus.raw_bit = b;
            step();
            hist.push_back(b);
            byte_v = {byte_v[6:0], b};
            if (trail_run(hist) >= int'(REP_LIMIT)) begin
               push_ev(1'b1, 8'h00, cyc);
               failed = 1'b1;
               break;
            end
         end
         if (failed) break;
         push_ev(1'b0, byte_v, due);
         d = $urandom_range(dmin, dmax);
         if (w == nwords - 1) bus.enable = 1'b0;
         repeat (d) begin
            step();
            check("hold_valid", 32'(bus.word_valid), 32'd1);
            check("hold_word", 32'(bus.word), 32'(byte_v));
            check("hold_ro_en", 32'(bus.ro_en), 32'd3);
         end
         bus.word_ready = 1'b1;
         step();
         bus.word_ready = 1'b0;
         due = cyc + 32'd8;
         check("handshake_clear", 32'(bus.word_valid), 32'd0);
         if (w == nwords - 1) begin
            check("end_busy", 32'(bus.busy), 32'd0);
            check("end_ro_en", 32'(bus.ro_en), 32'd0);
         end
      end
      if (failed) fail_recovery();
      bus.enable = 1'b0;
   endtask

   task automatic abort_collect();
      bus.enable = 1'b1;
      step();
      repeat (WARMUP) step();
      repeat (3) begin
         bus.raw_bit = 1'($urandom);
         step();
      end
      bus.enable = 1'b0;
      step();
      check("abort_ro_en", 32'(bus.ro_en), 32'd0);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_valid", 32'(bus.word_valid), 32'd0);
   endtask

   task automatic reset_in_hold();
      bus.word_ready = 1'b0;
      bus.enable     = 1'b1;
      step();
      push_ev(1'b0, 8'hAA, cyc + 32'(WARMUP) + 32'd8);
      repeat (WARMUP) step();
      for (int i = 0; i < 8; i++) begin
         bus.raw_bit = gen_bit(1, i);
         step();
      end
      step();
      check("pre_reset_valid", 32'(bus.word_valid), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(bus.word_valid), 32'd0);
      check("async_rst_word", 32'(bus.word), 32'd0);
      check("async_rst_ro_en", 32'(bus.ro_en), 32'd0);
      check("async_rst_busy", 32'(bus.busy), 32'd0);
      check("async_rst_fail", 32'(bus.health_fail), 32'd0);
      #4 rst_n = 1'b1;
      bus.enable = 1'b0;
      step();
      check("post_reset_busy", 32'(bus.busy), 32'd0);
      check("post_reset_valid", 32'(bus.word_valid), 32'd0);
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.enable     = 1'b0;
      bus.raw_bit    = 1'b0;
      bus.clr_fail   = 1'b0;
      bus.word_ready = 1'b0;
      #1;
      check("rst_ro_en", 32'(bus.ro_en), 32'd0);
      check("rst_word", 32'(bus.word), 32'd0);
      check("rst_valid", 32'(bus.word_valid), 32'd0);
      check("rst_fail", 32'(bus.health_fail), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      step();
      check("idle_after_release", 32'(bus.busy), 32'd0);

      episode(3, 1, 0, 0);   // alternating bits, full rate: AA every 9 cycles
      episode(2, 2, 5, 5);   // 11001100 with 5-cycle back-pressure
      episode(1, 3, 0, 0);   // stuck-at-0: health failure on 8th sample
      abort_collect();
      episode(2, 0, 0, 3);   // full latency again after abort
      reset_in_hold();
      for (int n = 0; n < 8; n++) episode($urandom_range(1, 4), 0, 0, 3);

      repeat (4) step();
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
